// File: rtl/core_writeback_if.sv
// Writeback-stage bus bundle: ALU result, load issue/return, decoder RAW query and register-file write port.
// The slave modport is the writeback core's view; the master modport is the surrounding pipeline.
interface core_writeback_if;
  logic        ALU_VALID;
  logic [4:0]  ALU_RD;
  logic [31:0] ALU_DATA;
  logic        LD_ISSUE;
  logic [4:0]  LD_RD;
  logic [2:0]  LD_FUNCT3;
  logic [1:0]  LD_BYTEOFF;
  logic        LD_RVALID;
  logic [31:0] LD_RDATA;
  logic        LD_RREADY;
  logic        LD_BUSY;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic        STALL;
  logic        AWVALID;
  logic [4:0]  AWADDR;
  logic [31:0] WDATA;

  modport slave (
    input  ALU_VALID, ALU_RD, ALU_DATA,
    input  LD_ISSUE, LD_RD, LD_FUNCT3, LD_BYTEOFF, LD_RVALID, LD_RDATA,
    input  RS1, RS2,
    output LD_RREADY, LD_BUSY, STALL, AWVALID, AWADDR, WDATA
  );

  modport master (
    output ALU_VALID, ALU_RD, ALU_DATA,
    output LD_ISSUE, LD_RD, LD_FUNCT3, LD_BYTEOFF, LD_RVALID, LD_RDATA,
    output RS1, RS2,
    input  LD_RREADY, LD_BUSY, STALL, AWVALID, AWADDR, WDATA
  );
endinterface

// File: rtl/core_writeback.sv
// Writeback arbiter: merges always-accepted ALU results with a single outstanding load,
// formats load data, tracks WAW kills and reports RAW stalls on the pending load.
module core_writeback (
  input  logic CLK,
  input  logic NRST,
  core_writeback_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, state_n;
  logic [4:0]  pend_rd, pend_rd_n;
  logic [2:0]  pend_f3, pend_f3_n;
  logic [1:0]  pend_off, pend_off_n;
  logic        kill, kill_n;
  logic [31:0] hold_data, hold_data_n;
  logic        vld_p1, vld_n;
  logic [4:0]  awaddr_p1, awaddr_n;
  logic [31:0] wdata_p1, wdata_n;

  logic        ld_hs;
  logic [31:0] ld_fmt;
  logic        ld_wr;
  logic [31:0] ld_data;
  logic        waw;

  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h  = off[1] ? word[31:16] : word[15:0];
    sb = signed'(b);
    sh = signed'(h);
    case (f3)
      3'b000:  return 32'(sb);
      3'b001:  return 32'(sh);
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  assign ld_hs  = (state == WAIT) && bus.LD_RVALID;
  assign ld_fmt = fmt_load(bus.LD_RDATA, pend_f3, pend_off);
  assign waw    = (state != IDLE) && bus.ALU_VALID && (bus.ALU_RD == pend_rd);

  always_comb begin
    state_n     = state;
    pend_rd_n   = pend_rd;
    pend_f3_n   = pend_f3;
    pend_off_n  = pend_off;
    kill_n      = kill;
    hold_data_n = hold_data;
    ld_wr       = 1'b0;
    ld_data     = hold_data;
    vld_n       = 1'b0;
    awaddr_n    = awaddr_p1;
    wdata_n     = wdata_p1;

    case (state)
      IDLE: begin
        if (bus.LD_ISSUE) begin
          pend_rd_n  = bus.LD_RD;
          pend_f3_n  = bus.LD_FUNCT3;
          pend_off_n = bus.LD_BYTEOFF;
          kill_n     = 1'b0;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (ld_hs) begin
          if (bus.ALU_VALID) begin
            hold_data_n = ld_fmt;
            state_n     = HOLD;
          end else begin
            ld_wr   = 1'b1;
            ld_data = ld_fmt;
            state_n = IDLE;
          end
        end
      end
      HOLD: begin
        if (!bus.ALU_VALID) begin
          ld_wr   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (waw)
      kill_n = 1'b1;

    // ALU always owns the write port; a load only writes when the ALU is silent.
    if (bus.ALU_VALID) begin
      vld_n = (bus.ALU_RD != 5'd0);
      if (vld_n) begin
        awaddr_n = bus.ALU_RD;
        wdata_n  = bus.ALU_DATA;
      end
    end else if (ld_wr) begin
      vld_n = (pend_rd != 5'd0) && !kill;
      if (vld_n) begin
        awaddr_n = pend_rd;
        wdata_n  = ld_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Stage p1: registered register-file write port plus pending-load bookkeeping.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      pend_rd   <= '0;
      pend_f3   <= '0;
      pend_off  <= '0;
      kill      <= 1'b0;
      hold_data <= '0;
      vld_p1    <= 1'b0;
      awaddr_p1 <= '0;
      wdata_p1  <= '0;
    end else begin
      pend_rd   <= pend_rd_n;
      pend_f3   <= pend_f3_n;
      pend_off  <= pend_off_n;
      kill      <= kill_n;
      hold_data <= hold_data_n;
      vld_p1    <= vld_n;
      awaddr_p1 <= awaddr_n;
      wdata_p1  <= wdata_n;
    end
  end

  assign bus.LD_BUSY   = (state != IDLE);
  assign bus.LD_RREADY = (state == WAIT);
  assign bus.STALL     = (state != IDLE) && (pend_rd != 5'd0) && !kill &&
                         ((bus.RS1 == pend_rd) || (bus.RS2 == pend_rd));
  assign bus.AWVALID   = vld_p1;
  assign bus.AWADDR    = awaddr_p1;
  assign bus.WDATA     = wdata_p1;

endmodule

// File: doc/core_writeback.md
CORE_WRITEBACK -- requirements
Module: core_writeback

Interface
REQ-001 SHALL have no parameters; all widths are fixed (XLEN 32, register index 5).
REQ-002 SHALL use synchronous, active-low reset NRST and clock CLK; all state updates on posedge CLK.
REQ-003 Ports (name  direction  width  meaning):
  CLK  in  1  clock
  NRST  in  1  synchronous active-low reset
  ALU_VALID  in  1  ALU result present this cycle
  ALU_RD  in  5  ALU destination register
  ALU_DATA  in  32  ALU result
  LD_ISSUE  in  1  load issued to memory this cycle
  LD_RD  in  5  load destination register
  LD_FUNCT3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
  LD_BYTEOFF  in  2  address[1:0] of the load
  LD_RVALID  in  1  memory read data valid
  LD_RDATA  in  32  memory read word
  LD_RREADY  out  1  read data accepted when high with LD_RVALID
  LD_BUSY  out  1  load outstanding; issue not accepted
  RS1, RS2  in  5 each  source registers of decoding instruction
  STALL  out  1  decoder must hold (RAW on pending load)
  AWVALID  out  1  register-file write enable
  AWADDR  out  5  register-file write index
  WDATA  out  32  register-file write data

Function
REQ-004 SHALL implement FSM states IDLE, WAIT, HOLD.
REQ-005 IDLE: LD_ISSUE=1 -> capture LD_RD, LD_FUNCT3, LD_BYTEOFF into pending registers; next state WAIT.
REQ-006 LD_ISSUE in WAIT or HOLD SHALL be ignored (issuer must honour LD_BUSY).
REQ-007 LD_BUSY SHALL be 1 in WAIT and HOLD, 0 in IDLE (decoded from state).
REQ-008 LD_RREADY SHALL be 1 only in WAIT; the handshake completes on LD_RVALID & LD_RREADY.
REQ-009 Load formatting: select byte/halfword lane by pending offset (halfword uses offset[1]); LB/LH sign-extend, LBU/LHU zero-extend; LW and any other funct3 pass the word unchanged.
REQ-010 WAIT + handshake + ALU_VALID=0 -> register-file write of the formatted load next cycle; next state IDLE.
REQ-011 WAIT + handshake + ALU_VALID=1 -> ALU write wins; formatted load data stored in the hold register; next state HOLD.
REQ-012 HOLD + ALU_VALID=0 -> held load written next cycle; next state IDLE. HOLD + ALU_VALID=1 -> ALU write; remain HOLD.
REQ-013 ALU results SHALL always be accepted; an ALU write appears on the port one cycle after ALU_VALID.
REQ-014 Write port SHALL be registered: AWVALID/AWADDR/WDATA update one cycle after the source event; AWVALID=0 in cycles with no write.
REQ-015 Writes with destination x0 SHALL be suppressed (AWVALID stays 0), but the FSM SHALL still advance.
REQ-016 WAW: ALU_VALID with ALU_RD equal to pending rd while in WAIT or HOLD SHALL set a kill flag; the load, when completed, is consumed but not written.
REQ-017 STALL SHALL be combinational: 1 iff state != IDLE, pending rd != 0, kill flag clear, and (RS1 == pending rd or RS2 == pending rd).
REQ-018 WDATA/AWADDR SHALL hold their last value when AWVALID=0.

Reset
REQ-019 NRST=0 SHALL force IDLE; clear the kill flag, pending and hold registers; and drive AWVALID=0, AWADDR=0, WDATA=0. LD_BUSY, LD_RREADY and STALL SHALL therefore read 0.
REQ-020 Reset during WAIT/HOLD SHALL discard the outstanding load; a late LD_RVALID after reset SHALL be ignored (LD_RREADY=0).

Verification
REQ-021 ALU_VALID, rd=5, data 0x1234_5678 -> next cycle AWVALID=1, AWADDR=5, WDATA=0x1234_5678.
REQ-022 LD_ISSUE rd=3 LB off=2; RDATA 0x0080_0000 with no ALU -> write x3=0xFFFF_FF80; LD_BUSY 1 from issue to completion.
REQ-023 LHU off=2, RDATA 0xBEEF_0000, ALU rd=7 in the same cycle -> x7 written first, x3=0x0000_BEEF the following idle cycle; FSM passes through HOLD.
REQ-024 Pending load rd=9; RS2=9 -> STALL=1; ALU writes x9 -> STALL=0, and the later load data is not written.
REQ-025 Load and ALU targeting x0 -> AWVALID never asserted; FSM returns to IDLE.
REQ-026 NRST low in WAIT, then LD_RVALID=1 -> no handshake, no write, all outputs 0.
